// File: rtl/mesm6_mem_arbiter_if.sv
// ============================================================================
// Module      : mesm6_mem_arbiter_if
// Description : Bundle of every bus signal around the two-master memory
//               arbiter: both requester ports, the shared read-data return,
//               the memory port and the status/grant signals.
//               slave  - arbiter view (serves the requesters, drives memory)
//               master - environment view (requesters plus the memory)
// Ports       : m0_* / m1_*   requester handshakes (level read/write, done)
//               m_rdata       shared read data, valid with mN_done
//               mem_*         single memory port
//               grant         one-hot owner, bus_error sticky, err_clear
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mesm6_mem_arbiter_if;
  logic        m0_read;
  logic        m0_write;
  logic [14:0] m0_addr;
  logic [47:0] m0_wdata;
  logic        m0_done;

  logic        m1_read;
  logic        m1_write;
  logic [14:0] m1_addr;
  logic [47:0] m1_wdata;
  logic        m1_done;

  logic [47:0] m_rdata;

  logic        mem_read;
  logic        mem_write;
  logic        mem_done;
  logic [14:0] mem_addr;
  logic [47:0] mem_data_read;
  logic [47:0] mem_data_write;

  logic [1:0]  grant;
  logic        bus_error;
  logic        err_clear;

  modport slave (
    input  m0_read, m0_write, m0_addr, m0_wdata,
    output m0_done,
    input  m1_read, m1_write, m1_addr, m1_wdata,
    output m1_done,
    output m_rdata,
    output mem_read, mem_write, mem_addr, mem_data_write,
    input  mem_done, mem_data_read,
    output grant, bus_error,
    input  err_clear
  );

  modport master (
    output m0_read, m0_write, m0_addr, m0_wdata,
    input  m0_done,
    output m1_read, m1_write, m1_addr, m1_wdata,
    input  m1_done,
    input  m_rdata,
    input  mem_read, mem_write, mem_addr, mem_data_write,
    output mem_done, mem_data_read,
    input  grant, bus_error,
    output err_clear
  );
endinterface

`default_nettype wire

// File: rtl/mesm6_mem_arbiter.sv
// ============================================================================
// Module      : mesm6_mem_arbiter
// Description : Round-robin arbiter sharing one 15-bit-address / 48-bit-data
//               memory port between the mesm6 core (master 0) and a second
//               master (DMA / console loader). Level handshake: a request is
//               held until its done pulse. The grant is locked for the whole
//               transaction; a watchdog terminates transactions the memory
//               never completes and raises a sticky bus error.
// Ports       : clk      rising-edge clock
//               reset    synchronous active-high reset
//               arb_if   bus bundle (slave view), see mesm6_mem_arbiter_if
// Parameters  : TIMEOUT  grant cycles allowed before forced termination,
//                        0 disables the watchdog
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mesm6_mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  mesm6_mem_arbiter_if.slave   arb_if
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_GNT0 = 2'd1;
  localparam logic [1:0] c_GNT1 = 2'd2;

  // Counter only has to reach TIMEOUT-1.
  localparam int                 c_WDT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_WDT_W-1:0] c_WDT_LAST = c_WDT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic               c_WDT_EN   = (TIMEOUT != 0);

  logic [1:0]         state_q, state_d;
  logic               last_q, last_d;
  logic [c_WDT_W-1:0] wdt_q, wdt_d;
  logic               bus_error_q, bus_error_d;
  logic [1:0]         grant_q, grant_d;

  logic        w_req0, w_req1;
  logic        w_active, w_sel;
  logic        w_sel_read, w_sel_write, w_sel_req;
  logic [14:0] w_sel_addr;
  logic [47:0] w_sel_wdata;
  logic        w_mem_fin, w_abandon, w_timeout, w_fin;

  assign w_req0 = arb_if.m0_read | arb_if.m0_write;
  assign w_req1 = arb_if.m1_read | arb_if.m1_write;

  // Reset gates the combinational outputs so a transaction caught by reset
  // never produces a done pulse or a memory request.
  assign w_active = ~reset & ((state_q == c_GNT0) | (state_q == c_GNT1));
  assign w_sel    = (state_q == c_GNT1);

  assign w_sel_read  = w_sel ? arb_if.m1_read  : arb_if.m0_read;
  assign w_sel_write = w_sel ? arb_if.m1_write : arb_if.m0_write;
  assign w_sel_addr  = w_sel ? arb_if.m1_addr  : arb_if.m0_addr;
  assign w_sel_wdata = w_sel ? arb_if.m1_wdata : arb_if.m0_wdata;
  assign w_sel_req   = w_sel_read | w_sel_write;

  // Priority inside a grant: memory completion, then abandon, then watchdog.
  assign w_mem_fin = w_active & arb_if.mem_done;
  assign w_abandon = w_active & ~arb_if.mem_done & ~w_sel_req;
  assign w_timeout = w_active & ~arb_if.mem_done & w_sel_req & c_WDT_EN &
                     (wdt_q == c_WDT_LAST);
  assign w_fin     = w_mem_fin | w_timeout;

  // Memory port: read/write forwarded unchanged, even both-high.
  assign arb_if.mem_read       = w_active & w_sel_read;
  assign arb_if.mem_write      = w_active & w_sel_write;
  assign arb_if.mem_addr       = w_active ? w_sel_addr  : 15'd0;
  assign arb_if.mem_data_write = w_active ? w_sel_wdata : 48'd0;

  assign arb_if.m0_done   = w_fin & ~w_sel;
  assign arb_if.m1_done   = w_fin &  w_sel;
  // A timeout completes with zero data; memory data only on a real done.
  assign arb_if.m_rdata   = w_mem_fin ? arb_if.mem_data_read : 48'd0;
  assign arb_if.grant     = grant_q;
  assign arb_if.bus_error = bus_error_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wdt_d   = wdt_q;
    case (state_q)
      c_IDLE: begin
        // On a tie the master that was not served last wins.
        if (w_req0 && (!w_req1 || last_q)) begin
          state_d = c_GNT0;
          last_d  = 1'b0;
          wdt_d   = '0;
        end else if (w_req1) begin
          state_d = c_GNT1;
          last_d  = 1'b1;
          wdt_d   = '0;
        end
      end
      c_GNT0, c_GNT1: begin
        if (w_fin || w_abandon) begin
          state_d = c_IDLE;
        end else begin
          wdt_d = wdt_q + c_WDT_W'(1);
        end
      end
      default: state_d = c_IDLE;
    endcase
    // Setting wins over a simultaneous clear.
    bus_error_d = w_timeout | (bus_error_q & ~arb_if.err_clear);
    grant_d     = {state_d == c_GNT1, state_d == c_GNT0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= c_IDLE;
      last_q      <= 1'b1;
      wdt_q       <= '0;
      bus_error_q <= 1'b0;
      grant_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      wdt_q       <= wdt_d;
      bus_error_q <= bus_error_d;
      grant_q     <= grant_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mesm6_mem_arbiter.sv
// ============================================================================
// Module      : tb_mesm6_mem_arbiter
// Description : Self-checking bench for mesm6_mem_arbiter. Directed stimulus
//               pushes the expected done events into a scoreboard queue; a
//               monitor pops and compares on every done pulse. A small memory
//               model answers after a programmable latency (or never).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mesm6_mem_arbiter;

  localparam int          TO      = 8;
  localparam logic [47:0] MEMDATA = 48'h0000_1111_2222;
  localparam logic [47:0] WDATA1  = 48'h7FFF_FFFF_FFFF;

  typedef struct packed {
    logic        m;
    logic [47:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mesm6_mem_arbiter_if bus ();

  mesm6_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk    (clk),
    .reset  (reset),
    .arb_if (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   mem_lat  = -1;   // grant cycles after the first before mem_done; -1 = never
  bit   force_done = 1'b0;
  int   act_cnt  = 0;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.m0_read = 1'b0; bus.m0_write = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_read = 1'b0; bus.m1_write = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.err_clear = 1'b0;
    mem_lat = -1;
    force_done = 1'b0;
  endtask

  // Leaves the caller at the drive point of the first cycle out of reset.
  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_done(input int n, input int maxc, input string name);
    bit got = 1'b0;
    for (int k = 0; k < maxc && !got; k++) begin
      @(negedge clk);
      got = (n != 0) ? bus.m1_done : bus.m0_done;
    end
    chk(name, 64'(got), 64'(1));
  endtask

  // Memory model.
  initial begin
    bus.mem_done      = 1'b0;
    bus.mem_data_read = MEMDATA;
    forever begin
      @(posedge clk);
      #2;
      if (bus.mem_read | bus.mem_write) act_cnt++;
      else act_cnt = 0;
      bus.mem_done = force_done || (mem_lat >= 0 && act_cnt == mem_lat + 1);
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (bus.m0_done | bus.m1_done) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: m0_done=%b m1_done=%b, no done expected",
                   bus.m0_done, bus.m1_done);
        end else begin
          e = sbq.pop_front();
          chk("done_master", 64'({bus.m1_done, bus.m0_done}), 64'(e.m ? 2'b10 : 2'b01));
          chk("done_rdata", 64'(bus.m_rdata), 64'(e.rdata));
        end
      end else begin
        chk("rdata_no_done", 64'(bus.m_rdata), 64'(0));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit       seen0, seen1;
    bit [1:0] first_grant;

    // ---- reset state ----
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    sample();
    chk("rst_grant", 64'(bus.grant), 64'(0));
    chk("rst_mem_rw", 64'({bus.mem_read, bus.mem_write}), 64'(0));
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(bus.mem_data_write), 64'(0));
    chk("rst_dones", 64'({bus.m0_done, bus.m1_done}), 64'(0));
    chk("rst_bus_error", 64'(bus.bus_error), 64'(0));
    step();
    reset = 1'b0;

    // ---- test 1: single master, 3-cycle memory ----
    bus.m0_read = 1'b1;
    bus.m0_addr = 15'h1234;
    mem_lat     = 3;
    sbq.push_back('{1'b0, MEMDATA});
    sample();
    chk("t1_grant_c0", 64'(bus.grant), 64'(0));
    chk("t1_mem_read_c0", 64'(bus.mem_read), 64'(0));
    for (int c = 1; c <= 4; c++) begin
      step();
      sample();
      chk("t1_grant", 64'(bus.grant), 64'(2'b01));
      chk("t1_mem_addr", 64'(bus.mem_addr), 64'(15'h1234));
      chk("t1_mem_read", 64'(bus.mem_read), 64'(1));
      chk("t1_m0_done", 64'(bus.m0_done), 64'(c == 4));
    end
    step();
    bus.m0_read = 1'b0;
    sample();
    chk("t1_grant_after", 64'(bus.grant), 64'(0));

    // ---- test 2: simultaneous requests after reset ----
    do_reset();
    bus.m0_read  = 1'b1; bus.m0_addr = 15'h0200; bus.m0_wdata = '0;
    bus.m1_write = 1'b1; bus.m1_addr = 15'h0100; bus.m1_wdata = WDATA1;
    mem_lat = 1;
    sbq.push_back('{1'b0, MEMDATA});
    sbq.push_back('{1'b1, MEMDATA});
    seen0 = 1'b0; seen1 = 1'b0; first_grant = 2'b00;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (seen0) bus.m0_read  = 1'b0;
      if (seen1) bus.m1_write = 1'b0;
      sample();
      chk("t2_wdata", 64'(bus.mem_data_write), 64'((bus.grant == 2'b10) ? WDATA1 : 48'd0));
      chk("t2_m1_done_in_g0", 64'(bus.m1_done && bus.grant == 2'b01), 64'(0));
      if (bus.grant == 2'b10) chk("t2_m1_addr", 64'(bus.mem_addr), 64'(15'h0100));
      if (first_grant == 2'b00 && bus.grant != 2'b00) first_grant = bus.grant;
      if (bus.m0_done) seen0 = 1'b1;
      if (bus.m1_done) seen1 = 1'b1;
    end
    chk("t2_first_grant", 64'(first_grant), 64'(2'b01));
    chk("t2_both_done", 64'({seen0, seen1}), 64'(2'b11));

    // ---- test 3: fairness, continuous requests, 1-cycle memory ----
    do_reset();
    bus.m0_read = 1'b1; bus.m0_addr = 15'h0011;
    bus.m1_read = 1'b1; bus.m1_addr = 15'h0022;
    mem_lat = 0;
    for (int t = 0; t < 6; t++) sbq.push_back('{((t % 2) == 1), MEMDATA});
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 12) begin
        bus.m0_read = 1'b0;
        bus.m1_read = 1'b0;
      end
      sample();
      if ((c % 2) == 0) chk("t3_grant_idle", 64'(bus.grant), 64'(0));
      else chk("t3_grant", 64'(bus.grant), 64'((((c - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10));
    end
    step();
    sample();
    chk("t3_grant_end", 64'(bus.grant), 64'(0));

    // ---- test 4: watchdog ----
    do_reset();
    bus.m1_read = 1'b1; bus.m1_addr = 15'h0055;
    sbq.push_back('{1'b1, 48'd0});
    for (int c = 1; c <= TO; c++) begin
      step();
      sample();
      chk("t4_grant", 64'(bus.grant), 64'(2'b10));
      chk("t4_m1_done", 64'(bus.m1_done), 64'(c == TO));
      chk("t4_err_before", 64'(bus.bus_error), 64'(0));
    end
    step();
    bus.m1_read = 1'b0;
    sample();
    chk("t4_grant_after", 64'(bus.grant), 64'(0));
    chk("t4_err_set", 64'(bus.bus_error), 64'(1));
    repeat (3) begin
      step();
      sample();
      chk("t4_err_sticky", 64'(bus.bus_error), 64'(1));
    end
    step();
    bus.err_clear = 1'b1;
    sample();
    chk("t4_err_clear_cycle", 64'(bus.bus_error), 64'(1));
    step();
    bus.err_clear = 1'b0;
    sample();
    chk("t4_err_cleared", 64'(bus.bus_error), 64'(0));
    step();
    bus.m1_read   = 1'b1;
    bus.err_clear = 1'b1;
    sbq.push_back('{1'b1, 48'd0});
    for (int c = 1; c <= TO; c++) begin
      step();
      sample();
      chk("t4b_grant", 64'(bus.grant), 64'(2'b10));
    end
    step();
    bus.err_clear = 1'b0;
    bus.m1_read   = 1'b0;
    sample();
    chk("t4_set_wins", 64'(bus.bus_error), 64'(1));

    // ---- test 5: abandon, then reset mid-grant ----
    do_reset();
    bus.m0_read = 1'b1; bus.m0_addr = 15'h0333;
    step();
    sample();
    chk("t5_grant_c1", 64'(bus.grant), 64'(2'b01));
    step();
    bus.m0_read = 1'b0;
    sample();
    chk("t5_grant_c2", 64'(bus.grant), 64'(2'b01));
    chk("t5_no_done", 64'(bus.m0_done), 64'(0));
    step();
    sample();
    chk("t5_idle_after_abandon", 64'(bus.grant), 64'(0));
    chk("t5_no_error", 64'(bus.bus_error), 64'(0));

    step();
    bus.m1_read = 1'b1; bus.m1_addr = 15'h0444;
    step();
    sample();
    chk("t5_grant_m1", 64'(bus.grant), 64'(2'b10));
    step();
    reset = 1'b1;
    sample();
    chk("t5_rst_no_done", 64'({bus.m0_done, bus.m1_done}), 64'(0));
    step();
    reset = 1'b0;
    bus.m0_read = 1'b1; bus.m0_addr = 15'h0555;
    mem_lat = 0;
    sbq.push_back('{1'b0, MEMDATA});
    sbq.push_back('{1'b1, MEMDATA});
    sample();
    chk("t5_rst_grant", 64'(bus.grant), 64'(0));
    chk("t5_rst_mem", 64'({bus.mem_read, bus.mem_write, bus.mem_addr}), 64'(0));
    chk("t5_rst_wdata", 64'(bus.mem_data_write), 64'(0));
    step();
    sample();
    chk("t5_tie_to_m0", 64'(bus.grant), 64'(2'b01));
    step();
    bus.m0_read = 1'b0;
    wait_done(1, 6, "t5_m1_served");
    step();
    bus.m1_read = 1'b0;

    // ---- test 6: mem_done while idle ----
    step();
    force_done = 1'b1;
    repeat (3) begin
      step();
      sample();
      chk("t6_grant_idle", 64'(bus.grant), 64'(0));
      chk("t6_no_done", 64'({bus.m0_done, bus.m1_done}), 64'(0));
    end
    step();
    force_done = 1'b0;
    sample();
    chk("t6_grant_end", 64'(bus.grant), 64'(0));

    step();
    step();
    chk("sb_empty", 64'(sbq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mesm6_mem_arbiter.md
# mesm6_mem_arbiter

Two-master arbiter that shares the single 15-bit-address, 48-bit-data memory port between the mesm6 core (master 0) and a second master (master 1: DMA/console loader). It uses the core's level handshake: read/write held until done. Grants are round-robin, locked for the whole transaction. A watchdog terminates transactions the memory never completes and records a sticky bus error.

## Interface
- TIMEOUT, default 255: cycles a granted transaction may wait for mem_done before forced termination; 0 disables the watchdog.
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- m0_read  in  1  master 0 read request, held until m0_done
- m0_write  in  1  master 0 write request, held until m0_done
- m0_addr  in  15  master 0 word address
- m0_wdata  in  48  master 0 write data
- m0_done  out  1  master 0 transaction complete (1-cycle pulse)
- m1_read, m1_write, m1_addr, m1_wdata, m1_done: same as m0_*, for master 1
- m_rdata  out  48  read data, shared by both masters; valid in the cycle of mN_done
- mem_read  out  1  request to memory
- mem_write  out  1  request to memory
- mem_done  in  1  memory operation completed
- mem_addr  out  15  memory address
- mem_data_read  in  48  memory read data
- mem_data_write  out  48  memory write data
- grant  out  2  one-hot current owner: 01 = m0, 10 = m1, 00 = idle
- bus_error  out  1  sticky watchdog flag
- err_clear  in  1  clears bus_error

## Operation
- States: IDLE, GNT0, GNT1. A 1-bit `last` pointer records the last master granted. Watchdog counter wdt is wide enough for TIMEOUT.
- reqN = mN_read | mN_write.
- IDLE: memory outputs are all zero, mN_done = 0, and mem_done is ignored.
  - Only one reqN is set: go to GNTN.
  - Both are set: grant the master other than `last`.
  - On entry to GNTn, set `last` to n and wdt to 0.
- GNTn: mem_read, mem_write, mem_addr and mem_data_write follow master n's inputs combinationally. Read and write are forwarded unchanged, including the illegal case where both are high. The other master's done stays 0.
- GNTn with mem_done = 1: mn_done = 1 in the same cycle. m_rdata = mem_data_read. Next state is IDLE.
- GNTn with mem_done = 0 and reqn = 0: the master abandoned the request. Next state is IDLE, with no done pulse and no error.
- GNTn with mem_done = 0, TIMEOUT != 0 and wdt == TIMEOUT-1: timeout cycle.
  - mn_done = 1 and m_rdata = 0.
  - bus_error is set and the next state is IDLE.
  - Otherwise, while waiting, wdt increments.
- m_rdata = 0 in every cycle where neither mN_done is asserted.
- bus_error: err_clear clears it. If set and clear happen in the same cycle, set wins.
- Reset: state IDLE, `last` = 1 (master 0 wins the first tie), wdt = 0, bus_error = 0. All outputs are 0: mem_read, mem_write, mem_addr, mem_data_write, mN_done, m_rdata, grant. Reset in the middle of a transaction drops it with no done pulse.

## Timing
- Arbitration is registered: a request first seen in cycle N is forwarded to memory in cycle N+1. A grant never changes in the cycle a request appears.
- Minimum transaction is 2 cycles: request in cycle 0, grant and mem_done in cycle 1, mN_done in cycle 1.
- Back-to-back: after a done in cycle k, IDLE arbitrates in cycle k+1 and the next grant starts in cycle k+2. A master asserting reqN continuously is therefore served at most every other cycle plus memory latency.
- Round-robin guarantees that the waiting master is served after at most one transaction by the other master.
- With the watchdog enabled, a transaction occupies GNTn for at most TIMEOUT cycles.
- grant is a registered decode of the state.

## Test plan
- Reset then single master: m0_read, addr 0x1234; memory asserts done 3 cycles after mem_read with data 0x0000_1111_2222.
  - Required: mem_addr = 0x1234 from cycle 1, m0_done in cycle 4 with m_rdata = 0x0000_1111_2222, grant = 01 during cycles 1-4.
- Simultaneous requests after reset: m0_read and m1_write (addr 0x0100, data 0x7FFF_FFFF_FFFF), both held until done.
  - Required: m0 is granted first, then m1. mem_data_write = 0x7FFF_FFFF_FFFF only during the m1 grant. m1_done never pulses during the m0 grant.
- Fairness: both masters request continuously for 6 transactions with 1-cycle memory.
  - Required: grant sequence 01,10,01,10,01,10, with an IDLE cycle between each.
- Watchdog, TIMEOUT = 8: m1_read granted, mem_done held low.
  - Required: m1_done in the 8th grant cycle, m_rdata = 0, bus_error = 1, next state IDLE.
  - bus_error stays high until an err_clear pulse clears it. err_clear together with a second timeout leaves it set.
- Abandon and reset: m0 drops m0_read in grant cycle 2 → IDLE next cycle, no m0_done, bus_error = 0.
  - Separately, reset asserted mid-grant → all outputs 0 the next cycle. The next tie then goes to m0.
- mem_done asserted while IDLE → ignored: no mN_done, no state change.
